// File: rtl/qdrc_phy_bit_align_multi_if.sv
// Bundle of data, configuration and readback signals for the per-bit read
// data alignment stage. The master side drives captured data and config;
// the slave side (the aligner) returns aligned data and readback.
interface qdrc_phy_bit_align_multi_if #(
    parameter int DATA_WIDTH = 36,
    parameter int DELAY_BITS = 2,
    parameter int SEL_BITS   = 6
);
    logic [DATA_WIDTH-1:0] qdr_q_rise;
    logic [DATA_WIDTH-1:0] qdr_q_fall;
    logic                  cfg_we;
    logic                  cfg_all;
    logic [SEL_BITS-1:0]   cfg_bit;
    logic                  cfg_half;
    logic [DELAY_BITS-1:0] cfg_delay;
    logic [SEL_BITS-1:0]   rd_bit;
    logic                  rd_half;
    logic [DELAY_BITS-1:0] rd_delay;
    logic [DATA_WIDTH-1:0] qdr_q_rise_cal;
    logic [DATA_WIDTH-1:0] qdr_q_fall_cal;
    logic                  cal_stable;

    modport master (
        output qdr_q_rise, qdr_q_fall, cfg_we, cfg_all, cfg_bit, cfg_half,
               cfg_delay, rd_bit,
        input  rd_half, rd_delay, qdr_q_rise_cal, qdr_q_fall_cal, cal_stable
    );

    modport slave (
        input  qdr_q_rise, qdr_q_fall, cfg_we, cfg_all, cfg_bit, cfg_half,
               cfg_delay, rd_bit,
        output rd_half, rd_delay, qdr_q_rise_cal, qdr_q_fall_cal, cal_stable
    );
endinterface

// File: rtl/qdrc_phy_bit_align_multi.sv
// Per-bit read-data alignment for the QDR PHY. Every bit owns a half-cycle
// rise/fall re-pairing flag and a whole-cycle delay, both writable at run
// time. A settle timer reports when the outputs again reflect the current
// configuration with a fully refilled pipeline.
module qdrc_phy_bit_align_multi #(
    parameter int DATA_WIDTH = 36,
    parameter int MAX_DELAY  = 3,
    parameter int DELAY_BITS = 2,
    parameter int SEL_BITS   = 6
) (
    input  logic                        clk0,
    input  logic                        reset,
    qdrc_phy_bit_align_multi_if.slave   bus
);

    // Chain depth: the fall tap of the deepest delay needs S[MAX_DELAY+1].
    localparam int STAGES   = MAX_DELAY + 2;
    localparam int TMR_BITS = $clog2(MAX_DELAY + 4);

    localparam logic [TMR_BITS-1:0]   TMR_LOAD = TMR_BITS'(MAX_DELAY + 3);
    localparam logic [TMR_BITS-1:0]   TMR_ONE  = TMR_BITS'(1);
    localparam logic [DELAY_BITS-1:0] DLY_MAX  = DELAY_BITS'(MAX_DELAY);
    localparam logic [SEL_BITS:0]     BIT_LIM  = (SEL_BITS + 1)'(DATA_WIDTH);

    // Saturate a requested delay to the deepest tap the chain provides.
    function automatic logic [DELAY_BITS-1:0] clamp_delay(input logic [DELAY_BITS-1:0] d);
        return (d > DLY_MAX) ? DLY_MAX : d;
    endfunction

    logic [DATA_WIDTH-1:0] rise_p [STAGES];
    logic [DATA_WIDTH-1:0] fall_p [STAGES];
    logic [DATA_WIDTH-1:0] half_q;
    logic [DELAY_BITS-1:0] dly_q [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] rise_tap;
    logic [DATA_WIDTH-1:0] fall_tap;
    logic [TMR_BITS-1:0]   settle_q;
    logic                  wr_hit;
    logic                  rd_hit;

    // A write counts only if it targets a real bit or is a broadcast.
    assign wr_hit = bus.cfg_we & (bus.cfg_all | ({1'b0, bus.cfg_bit} < BIT_LIM));
    assign rd_hit = ({1'b0, bus.rd_bit} < BIT_LIM);

    // ---- stage S[0..STAGES-1]: capture and whole-cycle delay chain ----
    // Reset on every stage keeps the chain as discrete flops.
    always_ff @(posedge clk0) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                rise_p[k] <= '0;
                fall_p[k] <= '0;
            end
        end else begin
            rise_p[0] <= bus.qdr_q_rise;
            fall_p[0] <= bus.qdr_q_fall;
            for (int k = 1; k < STAGES; k++) begin
                rise_p[k] <= rise_p[k-1];
                fall_p[k] <= fall_p[k-1];
            end
        end
    end

    // Per-bit tap select: half swap pairs this cycle's fall with next cycle's rise.
    always_comb begin
        rise_tap = '0;
        fall_tap = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            for (int k = 0; k <= MAX_DELAY; k++) begin
                if (dly_q[b] == DELAY_BITS'(k)) begin
                    rise_tap[b] = half_q[b] ? fall_p[k+1][b] : rise_p[k+1][b];
                    fall_tap[b] = half_q[b] ? rise_p[k][b]   : fall_p[k+1][b];
                end
            end
        end
    end

    // ---- output stage: register the selected taps ----
    always_ff @(posedge clk0) begin
        if (reset) begin
            bus.qdr_q_rise_cal <= '0;
            bus.qdr_q_fall_cal <= '0;
        end else begin
            bus.qdr_q_rise_cal <= rise_tap;
            bus.qdr_q_fall_cal <= fall_tap;
        end
    end

    // Per-bit configuration store; broadcast writes every bit identically.
    always_ff @(posedge clk0) begin
        if (reset) begin
            half_q <= '0;
            for (int b = 0; b < DATA_WIDTH; b++) begin
                dly_q[b] <= '0;
            end
        end else if (bus.cfg_we) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (bus.cfg_all || (bus.cfg_bit == SEL_BITS'(b))) begin
                    half_q[b] <= bus.cfg_half;
                    dly_q[b]  <= clamp_delay(bus.cfg_delay);
                end
            end
        end
    end

    // Registered readback; sees the stored value before any same-cycle write.
    always_ff @(posedge clk0) begin
        if (reset) begin
            bus.rd_half  <= 1'b0;
            bus.rd_delay <= '0;
        end else begin
            bus.rd_half  <= rd_hit ? half_q[bus.rd_bit] : 1'b0;
            bus.rd_delay <= rd_hit ? dly_q[bus.rd_bit]  : '0;
        end
    end

    // Settle timer: reload on reset or accepted write, flag stable at zero.
    always_ff @(posedge clk0) begin
        if (reset) begin
            settle_q       <= TMR_LOAD;
            bus.cal_stable <= 1'b0;
        end else if (wr_hit) begin
            settle_q       <= TMR_LOAD;
            bus.cal_stable <= 1'b0;
        end else begin
            if (settle_q != '0) begin
                settle_q <= settle_q - TMR_ONE;
            end
            bus.cal_stable <= (settle_q <= TMR_ONE);
        end
    end

endmodule

// File: tb/tb_qdrc_phy_bit_align_multi.sv
// Bench for the per-bit read-data aligner: directed steps followed by random
// traffic, compared every cycle against a history-based latency model.
module tb_qdrc_phy_bit_align_multi;

    localparam int DW = 36;
    localparam int MD = 3;
    localparam int DB = 2;
    localparam int SB = 6;
    localparam int HN = 2048;

    logic clk0 = 1'b0;
    logic reset;

    initial forever #5 clk0 = ~clk0;

    qdrc_phy_bit_align_multi_if #(.DATA_WIDTH(DW), .DELAY_BITS(DB), .SEL_BITS(SB)) bus ();

    qdrc_phy_bit_align_multi #(
        .DATA_WIDTH(DW), .MAX_DELAY(MD), .DELAY_BITS(DB), .SEL_BITS(SB)
    ) dut (
        .clk0  (clk0),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state: input history per cycle and config per bit.
    logic [DW-1:0] hist_r [HN];
    logic [DW-1:0] hist_f [HN];
    bit  cur_h  [DW] = '{default: 1'b0};
    bit  prev_h [DW] = '{default: 1'b0};
    int  cur_d  [DW] = '{default: 0};
    int  prev_d [DW] = '{default: 0};
    int  cyc      = 0;
    int  last_rst = -1;
    int  last_evt = 0;
    int  prev_rd  = 0;
    bit  prev_rst = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Input bit of cycle c, or 0 if that cycle was wiped by a later reset.
    function automatic logic bitv(input bit is_rise, input int c, input int b);
        if (c < 0 || c <= last_rst) return 1'b0;
        return is_rise ? hist_r[c][b] : hist_f[c][b];
    endfunction

    task automatic model_update();
        hist_r[cyc] = bus.qdr_q_rise;
        hist_f[cyc] = bus.qdr_q_fall;
        prev_h   = cur_h;
        prev_d   = cur_d;
        prev_rd  = int'(bus.rd_bit);
        prev_rst = reset;
        if (reset) begin
            for (int b = 0; b < DW; b++) begin
                cur_h[b] = 1'b0;
                cur_d[b] = 0;
            end
            last_rst = cyc;
            last_evt = cyc;
        end else if (bus.cfg_we && (bus.cfg_all || int'(bus.cfg_bit) < DW)) begin
            for (int b = 0; b < DW; b++) begin
                if (bus.cfg_all || int'(bus.cfg_bit) == b) begin
                    cur_h[b] = bus.cfg_half;
                    cur_d[b] = (int'(bus.cfg_delay) > MD) ? MD : int'(bus.cfg_delay);
                end
            end
            last_evt = cyc;
        end
    endtask

    // Outputs in cycle t: the pair from cycle t-3-d (half swap takes fall of
    // that cycle and rise of the following one), config as held in cycle t-1.
    task automatic model_check();
        logic [DW-1:0] er;
        logic [DW-1:0] ef;
        logic          eh;
        logic [DB-1:0] ed;
        er = '0;
        ef = '0;
        for (int b = 0; b < DW; b++) begin
            int c;
            c = cyc - 3 - prev_d[b];
            if (prev_h[b]) begin
                er[b] = bitv(1'b0, c, b);
                ef[b] = bitv(1'b1, c + 1, b);
            end else begin
                er[b] = bitv(1'b1, c, b);
                ef[b] = bitv(1'b0, c, b);
            end
        end
        if (prev_rst || prev_rd >= DW) begin
            eh = 1'b0;
            ed = '0;
        end else begin
            eh = prev_h[prev_rd];
            ed = DB'(prev_d[prev_rd]);
        end
        chk("m_rise_cal", bus.qdr_q_rise_cal, er);
        chk("m_fall_cal", bus.qdr_q_fall_cal, ef);
        chk("m_rd_half", bus.rd_half, eh);
        chk("m_rd_delay", bus.rd_delay, ed);
        chk("m_cal_stable", bus.cal_stable, (cyc >= last_evt + MD + 4));
    endtask

    task automatic tick();
        @(posedge clk0);
        model_update();
        cyc++;
        @(negedge clk0);
        model_check();
    endtask

    task automatic idle();
        bus.qdr_q_rise = '0;
        bus.qdr_q_fall = '0;
        bus.cfg_we     = 1'b0;
        bus.cfg_all    = 1'b0;
        bus.cfg_bit    = '0;
        bus.cfg_half   = 1'b0;
        bus.cfg_delay  = '0;
        bus.rd_bit     = '0;
    endtask

    task automatic write_bit(input int b, input bit h, input int d);
        bus.cfg_we    = 1'b1;
        bus.cfg_all   = 1'b0;
        bus.cfg_bit   = SB'(b);
        bus.cfg_half  = h;
        bus.cfg_delay = DB'(d);
    endtask

    initial begin
        int n;
        int w2;

        // Reset with rise all-ones held across release
        reset = 1'b1;
        idle();
        bus.qdr_q_rise = '1;
        tick();
        tick();
        chk("t1_rise_in_reset", bus.qdr_q_rise_cal, '0);
        chk("t1_fall_in_reset", bus.qdr_q_fall_cal, '0);
        chk("t1_stable_in_reset", bus.cal_stable, 1'b0);
        reset = 1'b0;
        while (cyc < 4) tick();
        chk("t1_rise_before_lat", bus.qdr_q_rise_cal, '0);
        tick();
        chk("t1_rise_lat3", bus.qdr_q_rise_cal, {DW{1'b1}});
        while (cyc < 7) tick();
        chk("t1_stable_low", bus.cal_stable, 1'b0);
        tick();
        chk("t1_stable_high", bus.cal_stable, 1'b1);

        // Single-cycle pair at default settings
        idle();
        tick();
        tick();
        n = cyc;
        bus.qdr_q_rise = 36'h0_1234_5678;
        bus.qdr_q_fall = 36'hF_EDCB_A987;
        tick();
        idle();
        while (cyc < n + 2) tick();
        chk("t2_rise_early", bus.qdr_q_rise_cal, '0);
        tick();
        chk("t2_rise", bus.qdr_q_rise_cal, 36'h0_1234_5678);
        chk("t2_fall", bus.qdr_q_fall_cal, 36'hF_EDCB_A987);
        tick();
        chk("t2_rise_after", bus.qdr_q_rise_cal, '0);
        chk("t2_fall_after", bus.qdr_q_fall_cal, '0);

        // Half swap on bit 5; bit 6 keeps plain timing
        write_bit(5, 1'b1, 0);
        bus.rd_bit = SB'(5);
        tick();
        bus.cfg_we = 1'b0;
        chk("t3_rd_half_old", bus.rd_half, 1'b0);
        tick();
        chk("t3_rd_half_new", bus.rd_half, 1'b1);
        n = cyc;
        bus.qdr_q_fall = DW'(1) << 5;
        tick();
        bus.qdr_q_fall = '0;
        bus.qdr_q_rise = (DW'(1) << 5) | (DW'(1) << 6);
        tick();
        idle();
        while (cyc < n + 3) tick();
        chk("t3_rise5", bus.qdr_q_rise_cal[5], 1'b1);
        chk("t3_fall5", bus.qdr_q_fall_cal[5], 1'b1);
        chk("t3_rise6_early", bus.qdr_q_rise_cal[6], 1'b0);
        tick();
        chk("t3_rise6", bus.qdr_q_rise_cal[6], 1'b1);
        chk("t3_rise5_after", bus.qdr_q_rise_cal[5], 1'b0);

        // Broadcast delay: 7 truncates to the 2-bit field as 3, the maximum
        bus.cfg_we    = 1'b1;
        bus.cfg_all   = 1'b1;
        bus.cfg_bit   = SB'(7);
        bus.cfg_half  = 1'b0;
        bus.cfg_delay = DB'(7);
        tick();
        idle();
        for (int i = 0; i < DW; i++) begin
            bus.rd_bit = SB'(i);
            tick();
            chk("t4_rd_delay", bus.rd_delay, 3);
        end
        bus.rd_bit = SB'(40);
        tick();
        chk("t4_rd_oob", bus.rd_delay, 0);
        idle();
        n = cyc;
        bus.qdr_q_rise = 36'hA_5A5A_5A5A;
        tick();
        idle();
        while (cyc < n + 5) tick();
        chk("t4_marker_early", bus.qdr_q_rise_cal, '0);
        tick();
        chk("t4_marker", bus.qdr_q_rise_cal, 36'hA_5A5A_5A5A);

        // Back-to-back writes reload the settle timer; out-of-range write ignored
        write_bit(0, 1'b0, 1);
        tick();
        bus.cfg_we = 1'b0;
        tick();
        tick();
        write_bit(0, 1'b0, 2);
        w2 = cyc;
        tick();
        bus.cfg_we = 1'b0;
        chk("t5_stable_after_w2", bus.cal_stable, 1'b0);
        while (cyc < w2 + 6) tick();
        chk("t5_stable_low", bus.cal_stable, 1'b0);
        tick();
        chk("t5_stable_high", bus.cal_stable, 1'b1);
        write_bit(40, 1'b1, 1);
        bus.rd_bit = SB'(0);
        tick();
        bus.cfg_we = 1'b0;
        chk("t5_oob_stable", bus.cal_stable, 1'b1);
        tick();
        chk("t5_oob_rd_delay", bus.rd_delay, 2);
        chk("t5_oob_rd_half", bus.rd_half, 1'b0);

        // Same-cycle write and read of bit 9
        write_bit(9, 1'b0, 0);
        tick();
        bus.cfg_we = 1'b0;
        tick();
        write_bit(9, 1'b0, 2);
        bus.rd_bit = SB'(9);
        tick();
        bus.cfg_we = 1'b0;
        chk("t6_rd_old", bus.rd_delay, 0);
        tick();
        chk("t6_rd_new", bus.rd_delay, 2);

        // Random traffic, writes, reads and occasional resets
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.qdr_q_rise = DW'({$urandom(), $urandom()});
            bus.qdr_q_fall = DW'({$urandom(), $urandom()});
            bus.cfg_we     = ($urandom_range(0, 5) == 0);
            bus.cfg_all    = ($urandom_range(0, 15) == 0);
            bus.cfg_bit    = SB'($urandom_range(0, 47));
            bus.cfg_half   = $urandom_range(0, 1) == 1;
            bus.cfg_delay  = DB'($urandom_range(0, 3));
            bus.rd_bit     = SB'($urandom_range(0, 47));
            tick();
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 10; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qdrc_phy_bit_align_multi.md
Name: qdrc_phy_bit_align_multi

Overview:
- Per-bit read-data alignment stage for the QDR PHY, generalised to DATA_WIDTH bits.
- Each bit has its own half-cycle swap (rise/fall re-pairing) and whole-cycle delay (0..MAX_DELAY), programmable at run time through a write port.
- Sits between the DDR input capture (rise/fall already in the clk0 domain) and the QDR read datapath.
- Flags when outputs are stable after reset or reconfiguration.

Parameters:
- DATA_WIDTH, 36, number of data bits (1..64)
- MAX_DELAY, 3, largest whole-cycle delay selectable per bit (>=1)
- DELAY_BITS, 2, width of delay fields (2**DELAY_BITS > MAX_DELAY)
- SEL_BITS, 6, width of bit-index fields (2**SEL_BITS >= DATA_WIDTH)

Ports:
- clk0  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- qdr_q_rise  input  DATA_WIDTH  rise-edge captured data
- qdr_q_fall  input  DATA_WIDTH  fall-edge captured data
- cfg_we  input  1  write strobe, one write per asserted cycle
- cfg_all  input  1  with cfg_we: write all bits, ignore cfg_bit
- cfg_bit  input  SEL_BITS  bit index to write
- cfg_half  input  1  1 = half-cycle swap for that bit
- cfg_delay  input  DELAY_BITS  extra whole-cycle delay for that bit
- rd_bit  input  SEL_BITS  readback index
- rd_half  output  1  registered readback of half setting
- rd_delay  output  DELAY_BITS  registered readback of delay setting
- qdr_q_rise_cal  output  DATA_WIDTH  aligned rise data
- qdr_q_fall_cal  output  DATA_WIDTH  aligned fall data
- cal_stable  output  1  outputs reflect current config with a full pipeline

Behaviour:
- Clocking and reset:
  - Single clock clk0.
  - Reset is synchronous, active-high.
  - Reset clears all per-bit config to half=0, delay=0.
  - Reset clears every pipeline stage, both _cal outputs, rd_half and rd_delay to 0.
  - Reset clears cal_stable to 0.
- Pipeline:
  - Per bit, a chain S[0..MAX_DELAY+1] of {rise,fall} pairs.
  - S[0] registers the inputs; S[k] <= S[k-1].
  - No shift-register inference on the chain.
- Output taps (per bit b, registered into the _cal outputs):
  - half=0: rise_cal <= S[1+d].rise, fall_cal <= S[1+d].fall.
  - half=1: rise_cal <= S[1+d].fall, fall_cal <= S[d].rise.
- Latency (input pair presented in cycle n):
  - half=0: the pair appears on the outputs in cycle n+3+d.
  - half=1: in cycle n+3+d, rise_cal carries fall of cycle n and fall_cal carries rise of cycle n+1.
- Config writes:
  - Take effect on the tap select from the cycle after cfg_we.
  - cfg_all=1 writes every bit identically.
  - cfg_bit >= DATA_WIDTH with cfg_all=0: write ignored, settle timer untouched.
  - cfg_delay > MAX_DELAY is clamped to MAX_DELAY, and the clamped value is stored and read back.
- Readback: rd_half/rd_delay are registered from config[rd_bit] with 1-cycle latency. Out-of-range rd_bit returns 0.
  - If a write and a read target the same bit in the same cycle, the read returns the old value. The new value is visible one cycle later.
- Settle timer:
  - Loads MAX_DELAY+3 on reset and on every accepted write.
  - Decrements to 0; cal_stable=1 only when it is 0.
  - A write while counting reloads the timer, so cal_stable stays 0.
  - After reset release, cal_stable rises in the (MAX_DELAY+4)th cycle.
- Outputs of bits not being rewritten are never disturbed by a write to another bit.

Test Plan:
1. Reset held 2 cycles, then released, with input rise=all-ones and fall=0 → both _cal outputs 0 during reset. cal_stable=0 until 7 cycles after release (MAX_DELAY=3), then 1. rise_cal=all-ones from cycle n+3.
2. Defaults half=0, d=0; drive rise=36'h0_1234_5678, fall=36'hF_EDCB_A987 in cycle n only, zeros elsewhere → exactly those values on rise_cal/fall_cal in cycle n+3 only.
3. Write bit 5 with half=1, d=0; drive rise[5]=1 in cycle n+1 only and fall[5]=1 in cycle n only → rise_cal[5]=1 and fall_cal[5]=1 together in cycle n+3. Other bits keep half=0 timing.
4. Broadcast write cfg_all=1 with d=7 → every rd_delay reads 3. A marker presented in cycle n appears in cycle n+6.
5. Writes to bit 0 on two cycles 3 apart → cal_stable stays 0 until 6 cycles after the second write. A write with cfg_bit=40 leaves config and cal_stable unchanged.
6. Same-cycle write and read of bit 9 (old delay 0, new delay 2) → rd_delay=0 first, 2 on the next read.
